rv64i_ctrl_fsm: RTL and testbench
=================================

# rv64i_ctrl_fsm

Multi-cycle control FSM that sequences the RV64I datapath, one instruction at a time. Each instruction passes through fetch, decode, execute, optional memory and write-back. Per state, the block drives the datapath's IR/PC/regfile write enables, mux selects, ALU controls and memory request handshakes. It sits beside `datapath`, reads the latched instruction word and branch compare result, and owns the instruction- and data-memory handshakes.

## Interface
- `WAIT_MAX`, default 255: cycles a memory request may stay unacknowledged before a timeout trap; legal range 1–65535.
- Ports:
  - `clk`  in  1  rising-edge clock
  - `rst_n`  in  1  reset, asynchronous and active-low (one clock, `clk`)
  - `instr`  in  32  IR contents from datapath, valid from DECODE onward
  - `br_taken`  in  1  datapath branch-compare result, valid in EXEC
  - `imem_req`  out  1  instruction fetch request
  - `imem_ready`  in  1  fetch acknowledge; data valid same cycle
  - `dmem_req`  out  1  data access request
  - `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req`
  - `dmem_ready`  in  1  data access acknowledge
  - `ir_we`  out  1  latch fetched word into IR
  - `pc_we`  out  1  update PC
  - `pc_src`  out  2  0 = pc+4, 1 = pc+imm (branch/JAL), 2 = (rs1+imm)&~1 (JALR)
  - `imm_sel`  out  3  I/S/B/U/J immediate format
  - `alu_src_a`  out  1  0 = rs1, 1 = pc (AUIPC)
  - `alu_src_b`  out  1  0 = rs2, 1 = imm
  - `alu_op`  out  4  ALU operation code
  - `alu_word`  out  1  32-bit op with sign-extend (OP-32/OP-IMM-32)
  - `wb_sel`  out  2  0 = ALU, 1 = load data, 2 = pc+4, 3 = imm (LUI)
  - `reg_we`  out  1  regfile write
  - `retire`  out  1  one-cycle pulse per completed instruction
  - `trap`  out  1  sticky; FSM halted
  - `trap_cause`  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout

## Operation
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- RESET: entered asynchronously on `rst_n`=0; all outputs 0. Moves to FETCH on the first clock after release.
- FETCH: `imem_req`=1 until `imem_ready`. In the ready cycle, assert `ir_we` and go to DECODE.
- DECODE: classify `instr[6:0]` and register the class, funct3, funct7[5] and rd.
  - Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP-IMM-32, OP, OP-32, MISC-MEM (NOP).
  - Any other opcode, including SYSTEM → TRAP with cause 1.
- EXEC: drive ALU controls from funct3/funct7[5].
  - BRANCH: `pc_we`=1, `pc_src`=`br_taken`?1:0, `retire`=1, then FETCH.
  - MISC-MEM: `pc_we`=1 with pc+4, `retire`=1, then FETCH.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM: hold `dmem_req` until `dmem_ready`, with address, `dmem_we` and ALU controls stable.
  - On ready, a LOAD goes to WB.
  - On ready, a STORE asserts `pc_we` (pc+4) and `retire`, then goes to FETCH.
- WB: `reg_we`=1 if rd≠0, `pc_we`=1, `retire`=1, then FETCH. PC source: JAL → 1, JALR → 2, otherwise 0.
- Timeout: a 16-bit counter clears on entering FETCH or MEM and increments each cycle the request is unacknowledged. When it reaches `WAIT_MAX` without ready → TRAP with cause 2 (FETCH) or 3 (MEM).
- TRAP is absorbing: all enables 0 and `trap`=1 until reset.
- Outputs are a combinational function of the state and the registered decode fields only; they never depend combinationally on `instr` after DECODE.

## Timing
- Best-case CPI, with ready in the request cycle:
  - BRANCH and MISC-MEM: 3 cycles.
  - ALU ops, LUI, AUIPC, JAL, JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each cycle of `imem_ready`/`dmem_ready` delay adds one cycle.
- Request handshake: `req` is held high until ready. `ready` without `req` is ignored.
- A ready arriving in the same cycle the counter reaches `WAIT_MAX` counts as success, not timeout.
- Reset mid-request drops `imem_req`/`dmem_req` immediately (asynchronously), with no partial retire.

## Structure
- `rv64i_pkg` holds:
  - opcode constants
  - `state_t` enum
  - `alu_op_t` (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB)
  - `imm_sel_t`, `pc_src_t`, `wb_sel_t`
  - `trap_cause_t`
- One sub-module, `rv64i_alu_dec`: combinational mapping from class/funct3/funct7[5] to `alu_op`, `alu_word`, `alu_src_b`, `imm_sel`.

## Test plan
- Reset, then supply 0x02A00193 (ADDI x3,x0,42), 0x00D00293 (ADDI x5,x0,13), 0x00328133 (ADD x2,x5,x3), all with immediate ready.
  - Three `retire` pulses, 4 cycles apart.
  - `reg_we` in each WB.
  - Third instruction has `alu_op`=ADD and `alu_src_b`=0.
- 0x00000463 (BEQ x0,x0,+8) with `br_taken`=1 → EXEC has `pc_we`=1, `pc_src`=1, `retire`=1, no `reg_we`; the next cycle is FETCH.
- 0x00002083 (LW x1,0(x0)) with `dmem_ready` delayed 3 cycles → `dmem_req` high 4 cycles with `dmem_we`=0, then WB with `wb_sel`=1; total 8 cycles.
- Instruction 0x00000000 → TRAP: `trap`=1, `trap_cause`=1; no further `imem_req` until `rst_n` pulse.
- `WAIT_MAX`=4, `imem_ready` held 0 → `trap_cause`=2 after 4 request cycles. Repeat with a ready on the 4th cycle → normal DECODE.
- Assert `rst_n`=0 mid-MEM → all outputs 0 immediately; after release, RESET then FETCH.

Source files
------------

// File: rtl/rv64i_pkg.sv
// rv64i_pkg: shared definitions for the RV64I multi-cycle control FSM.
//   - opcode constants for the legal RV64I major opcodes
//   - state_t      : FSM states
//   - class_t      : instruction class registered in DECODE
//   - alu_op_t     : ALU operation codes driven to the datapath
//   - imm_sel_t    : immediate format selector
//   - pc_src_t     : next-PC source selector
//   - wb_sel_t     : register write-back source selector
//   - trap_cause_t : reason the FSM halted
//   - classify()   : opcode -> instruction class
package rv64i_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_MISCMEM  = 7'b0001111;

  typedef enum logic [2:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD, CLS_STORE,
    CLS_OPIMM, CLS_OPIMM32, CLS_OP, CLS_OP32, CLS_MISC, CLS_ILLEGAL
  } class_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JALR} pc_src_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;
  typedef enum logic [1:0] {
    TC_NONE, TC_ILLEGAL, TC_IMEM_TIMEOUT, TC_DMEM_TIMEOUT
  } trap_cause_t;

  function automatic class_t classify(input logic [6:0] opc);
    case (opc)
      OPC_LUI:     return CLS_LUI;
      OPC_AUIPC:   return CLS_AUIPC;
      OPC_JAL:     return CLS_JAL;
      OPC_JALR:    return CLS_JALR;
      OPC_BRANCH:  return CLS_BRANCH;
      OPC_LOAD:    return CLS_LOAD;
      OPC_STORE:   return CLS_STORE;
      OPC_OPIMM:   return CLS_OPIMM;
      OPC_OPIMM32: return CLS_OPIMM32;
      OPC_OP:      return CLS_OP;
      OPC_OP32:    return CLS_OP32;
      OPC_MISCMEM: return CLS_MISC;
      default:     return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/rv64i_alu_dec.sv
// rv64i_alu_dec: combinational ALU/immediate control decoder.
// Ports:
//   cls_i       in  registered instruction class
//   funct3_i    in  registered funct3
//   funct7b5_i  in  registered funct7[5] (instr[30])
//   alu_op_o    out ALU operation
//   alu_word_o  out 32-bit operation with sign extension
//   alu_src_b_o out 0 = rs2, 1 = immediate
//   imm_sel_o   out immediate format
import rv64i_pkg::*;

module rv64i_alu_dec (
  input  class_t     cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output alu_op_t    alu_op_o,
  output logic       alu_word_o,
  output logic       alu_src_b_o,
  output imm_sel_t   imm_sel_o
);

  logic    reg_form;
  alu_op_t arith_op;

  // Only register-register forms use instr[30] to pick SUB; for OP-IMM it is
  // immediate bits, except on shifts where it selects arithmetic right shift.
  assign reg_form = (cls_i == CLS_OP) || (cls_i == CLS_OP32);

  always_comb begin
    arith_op = ALU_ADD;
    case (funct3_i)
      3'd0: arith_op = (reg_form && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'd1: arith_op = ALU_SLL;
      3'd2: arith_op = ALU_SLT;
      3'd3: arith_op = ALU_SLTU;
      3'd4: arith_op = ALU_XOR;
      3'd5: arith_op = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'd6: arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    alu_op_o    = ALU_ADD;
    alu_word_o  = 1'b0;
    alu_src_b_o = 1'b1;
    imm_sel_o   = IMM_I;
    case (cls_i)
      CLS_OP: begin
        alu_op_o    = arith_op;
        alu_src_b_o = 1'b0;
      end
      CLS_OP32: begin
        alu_op_o    = arith_op;
        alu_src_b_o = 1'b0;
        alu_word_o  = 1'b1;
      end
      CLS_OPIMM:   alu_op_o = arith_op;
      CLS_OPIMM32: begin
        alu_op_o   = arith_op;
        alu_word_o = 1'b1;
      end
      CLS_STORE:   imm_sel_o = IMM_S;
      // Branch target comes from the PC adder; the ALU compares rs1 - rs2.
      CLS_BRANCH: begin
        alu_op_o    = ALU_SUB;
        alu_src_b_o = 1'b0;
        imm_sel_o   = IMM_B;
      end
      CLS_LUI: begin
        alu_op_o  = ALU_PASSB;
        imm_sel_o = IMM_U;
      end
      CLS_AUIPC:   imm_sel_o = IMM_U;
      CLS_JAL:     imm_sel_o = IMM_J;
      CLS_MISC:    alu_src_b_o = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv64i_ctrl_fsm.sv
// rv64i_ctrl_fsm: multi-cycle control FSM for the RV64I datapath.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> WB, one instruction at a time,
// and owns the instruction/data memory request handshakes.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   instr, br_taken             IR contents and branch compare from datapath
//   imem_req/imem_ready         instruction fetch handshake
//   dmem_req/dmem_we/dmem_ready data access handshake
//   ir_we, pc_we, pc_src        IR / PC update controls
//   imm_sel, alu_src_a/b, alu_op, alu_word   ALU and immediate controls
//   wb_sel, reg_we              register write-back controls
//   retire                      one pulse per completed instruction
//   trap, trap_cause            sticky halt indication and reason
import rv64i_pkg::*;

module rv64i_ctrl_fsm #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic        alu_word,
  output logic [1:0]  wb_sel,
  output logic        reg_we,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  state_t      state_q, state_d;
  class_t      cls_q, cls_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        funct7b5_q, funct7b5_d;
  logic [4:0]  rd_q, rd_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  trap_cause_t cause_q, cause_d;

  class_t   dec_cls;
  alu_op_t  dec_alu_op;
  logic     dec_alu_word;
  logic     dec_alu_src_b;
  imm_sel_t dec_imm_sel;
  logic     wait_expired;
  logic     unused_instr_bits;

  assign dec_cls           = classify(instr[6:0]);
  assign unused_instr_bits = ^{instr[31], instr[29:15]};

  // The request cycle that would bring the counter to WAIT_MAX is the last
  // one allowed; a ready in that same cycle still wins.
  assign wait_expired = ({1'b0, wait_cnt_q} + 17'd1) == 17'(WAIT_MAX);

  rv64i_alu_dec u_alu_dec (
    .cls_i       (cls_q),
    .funct3_i    (funct3_q),
    .funct7b5_i  (funct7b5_q),
    .alu_op_o    (dec_alu_op),
    .alu_word_o  (dec_alu_word),
    .alu_src_b_o (dec_alu_src_b),
    .imm_sel_o   (dec_imm_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      cls_q      <= CLS_ILLEGAL;
      funct3_q   <= 3'd0;
      funct7b5_q <= 1'b0;
      rd_q       <= 5'd0;
      wait_cnt_q <= 16'd0;
      cause_q    <= TC_NONE;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      rd_q       <= rd_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    rd_d       = rd_q;
    cause_d    = cause_q;
    // Counter runs only while a request waits; any other state clears it,
    // so every entry into FETCH or MEM starts from zero.
    wait_cnt_d = 16'd0;

    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    imm_sel    = IMM_I;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    alu_word   = 1'b0;
    wb_sel     = WB_ALU;
    reg_we     = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;
    trap_cause = TC_NONE;

    // ALU/immediate controls stay stable from EXEC through WB.
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      imm_sel   = dec_imm_sel;
      alu_src_a = (cls_q == CLS_AUIPC);
      alu_src_b = dec_alu_src_b;
      alu_op    = dec_alu_op;
      alu_word  = dec_alu_word;
    end

    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = TC_IMEM_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_DECODE: begin
        cls_d      = dec_cls;
        funct3_d   = instr[14:12];
        funct7b5_d = instr[30];
        rd_d       = instr[11:7];
        if (dec_cls == CLS_ILLEGAL) begin
          state_d = ST_TRAP;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = br_taken ? PC_BRANCH : PC_PLUS4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CLS_MISC: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (dmem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = TC_DMEM_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_WB: begin
        reg_we  = (rd_q != 5'd0);
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
        case (cls_q)
          CLS_JAL:  pc_src = PC_BRANCH;
          CLS_JALR: pc_src = PC_JALR;
          default:  pc_src = PC_PLUS4;
        endcase
        case (cls_q)
          CLS_LOAD:          wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
          CLS_LUI:           wb_sel = WB_IMM;
          default:           wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end
      default: state_d = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_rv64i_ctrl_fsm.sv
// Self-checking bench for rv64i_ctrl_fsm: directed steps followed by random
// instructions with random memory latencies, compared to a per-instruction
// model of cycle counts and per-class control values.
module tb_rv64i_ctrl_fsm;
  import rv64i_pkg::*;

  localparam int TB_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        br_taken = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]  pc_src, wb_sel, trap_cause;
  logic [2:0]  imm_sel;
  logic        alu_src_a, alu_src_b, alu_word, reg_we, retire, trap;
  logic [3:0]  alu_op;

  always #5 clk = ~clk;

  rv64i_ctrl_fsm #(.WAIT_MAX(TB_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_word(alu_word), .wb_sel(wb_sel), .reg_we(reg_we), .retire(retire),
    .trap(trap), .trap_cause(trap_cause)
  );

  wire [23:0] all_outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
                          imm_sel, alu_src_a, alu_src_b, alu_op, alu_word,
                          wb_sel, reg_we, retire, trap, trap_cause};

  int n_assert = 0;
  int n_fail   = 0;

  // Observations collected by run()
  int          o_cycles, o_ireq, o_dreq, o_dwe, o_regwe, o_pcwe, o_retires;
  logic        o_trap, o_word, o_srca, o_srcb;
  logic [1:0]  o_cause, o_pcsrc, o_wbsel;
  logic [3:0]  o_aop;
  logic [2:0]  o_imm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                     OPC_STORE, OPC_OPIMM, OPC_OPIMM32, OPC_OP, OPC_OP32, OPC_MISCMEM};
  endfunction

  // RISC-V arithmetic selection: funct3 picks the operation; instr[30]
  // selects SUB only in register form and SRA for right shifts.
  function automatic logic [3:0] exp_arith(input bit reg_form, input logic [2:0] f3, input logic b30);
    case (f3)
      3'd0: return (reg_form && b30) ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return b30 ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("reset_outputs_zero", 32'(all_outs), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release_no_req", 32'(imem_req), 32'd0);
  endtask

  // Acts as instruction/data memory for one instruction: ready is returned
  // after idel / ddel unacknowledged request cycles. Stops at retire or trap.
  task automatic run(input logic [31:0] w, input int idel, input int ddel, input logic br);
    int iw, dw, dec_cnt;
    bit done;
    iw = 0; dw = 0; dec_cnt = -1; done = 0;
    o_cycles = 0; o_ireq = 0; o_dreq = 0; o_dwe = 0; o_regwe = 0; o_pcwe = 0;
    o_retires = 0; o_trap = 0; o_cause = 0; o_pcsrc = 0; o_wbsel = 0;
    o_aop = 0; o_imm = 0; o_word = 0; o_srca = 0; o_srcb = 0;
    while (!done && o_cycles < 40) begin
      @(negedge clk);
      imem_ready = 1'b0; dmem_ready = 1'b0;
      if (o_cycles == 0) begin
        instr = w; br_taken = br;
      end else if (dec_cnt >= 1) begin
        instr = $urandom;  // decode is over; outputs must ignore instr now
      end
      #1;
      if (imem_req) begin imem_ready = (iw == idel); iw++; o_ireq++; end
      if (dmem_req) begin
        dmem_ready = (dw == ddel); dw++; o_dreq++;
        if (dmem_we) o_dwe++;
      end
      #1;
      o_cycles++;
      if (ir_we) dec_cnt = 0; else if (dec_cnt >= 0) dec_cnt++;
      if (reg_we) o_regwe++;
      if (pc_we) o_pcwe++;
      if (retire) begin
        o_retires++; done = 1;
        o_pcsrc = pc_src; o_wbsel = wb_sel; o_aop = alu_op; o_imm = imm_sel;
        o_word = alu_word; o_srca = alu_src_a; o_srcb = alu_src_b;
      end
      if (trap) begin o_trap = 1'b1; o_cause = trap_cause; done = 1; end
    end
  endtask

  task automatic check_instr(input string name, input logic [31:0] w, input int idel,
                             input int ddel, input logic br);
    logic [6:0] opc;
    bit legal, is_mem, is_st, writes, e_trap, reg_form;
    int e_cyc, e_ireq, e_dreq, e_cause, base;
    logic [1:0] e_pcsrc, e_wb;
    logic [2:0] e_imm;
    opc      = w[6:0];
    legal    = is_legal(opc);
    is_mem   = (opc == OPC_LOAD) || (opc == OPC_STORE);
    is_st    = (opc == OPC_STORE);
    writes   = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
                           OPC_OPIMM, OPC_OPIMM32, OPC_OP, OPC_OP32};
    reg_form = (opc == OPC_OP) || (opc == OPC_OP32);
    base     = (opc == OPC_BRANCH || opc == OPC_MISCMEM) ? 3 : (opc == OPC_LOAD) ? 5 : 4;
    e_trap = 0; e_cause = 0; e_dreq = 0;
    if (idel >= TB_WAIT) begin
      e_trap = 1; e_cause = 2; e_ireq = TB_WAIT; e_cyc = TB_WAIT + 1;
    end else begin
      e_ireq = idel + 1;
      if (!legal) begin
        e_trap = 1; e_cause = 1; e_cyc = idel + 3;
      end else if (is_mem && ddel >= TB_WAIT) begin
        e_trap = 1; e_cause = 3; e_dreq = TB_WAIT; e_cyc = idel + 1 + 2 + TB_WAIT + 1;
      end else begin
        e_cyc  = base + idel + (is_mem ? ddel : 0);
        e_dreq = is_mem ? ddel + 1 : 0;
      end
    end
    e_pcsrc = (opc == OPC_BRANCH) ? (br ? 2'd1 : 2'd0) :
              (opc == OPC_JAL) ? 2'd1 : (opc == OPC_JALR) ? 2'd2 : 2'd0;
    e_wb    = (opc == OPC_LOAD) ? 2'd1 : (opc == OPC_JAL || opc == OPC_JALR) ? 2'd2 :
              (opc == OPC_LUI) ? 2'd3 : 2'd0;
    case (opc)
      OPC_STORE:          e_imm = IMM_S;
      OPC_BRANCH:         e_imm = IMM_B;
      OPC_LUI, OPC_AUIPC: e_imm = IMM_U;
      OPC_JAL:            e_imm = IMM_J;
      default:            e_imm = IMM_I;
    endcase

    run(w, idel, ddel, br);
    $display("%s instr=%08h idel=%0d ddel=%0d br=%0d cycles=%0d trap=%0d cause=%0d",
             name, w, idel, ddel, br, o_cycles, o_trap, o_cause);

    chk({name, "_cycles"}, o_cycles, e_cyc);
    chk({name, "_trap"}, 32'(o_trap), 32'(e_trap));
    chk({name, "_imem_req_cycles"}, o_ireq, e_ireq);
    chk({name, "_dmem_req_cycles"}, o_dreq, e_dreq);
    chk({name, "_dmem_we_cycles"}, o_dwe, is_st ? e_dreq : 0);
    if (e_trap) begin
      chk({name, "_trap_cause"}, 32'(o_cause), e_cause);
      chk({name, "_no_retire"}, o_retires, 0);
      chk({name, "_no_pc_we"}, o_pcwe, 0);
      chk({name, "_no_reg_we"}, o_regwe, 0);
    end else begin
      chk({name, "_retire"}, o_retires, 1);
      chk({name, "_pc_we"}, o_pcwe, 1);
      chk({name, "_reg_we"}, o_regwe, (writes && w[11:7] != 5'd0) ? 1 : 0);
      chk({name, "_pc_src"}, 32'(o_pcsrc), 32'(e_pcsrc));
      if (writes) chk({name, "_wb_sel"}, 32'(o_wbsel), 32'(e_wb));
      chk({name, "_alu_word"}, 32'(o_word), (opc == OPC_OP32 || opc == OPC_OPIMM32) ? 1 : 0);
      chk({name, "_alu_src_a"}, 32'(o_srca), (opc == OPC_AUIPC) ? 1 : 0);
      if (!reg_form && opc != OPC_MISCMEM) chk({name, "_imm_sel"}, 32'(o_imm), 32'(e_imm));
      if (reg_form || opc == OPC_OPIMM || opc == OPC_OPIMM32) begin
        chk({name, "_alu_op"}, 32'(o_aop), 32'(exp_arith(reg_form, w[14:12], w[30])));
        chk({name, "_alu_src_b"}, 32'(o_srcb), reg_form ? 0 : 1);
      end
      if (is_mem) begin
        chk({name, "_alu_op"}, 32'(o_aop), 32'(ALU_ADD));
        chk({name, "_alu_src_b"}, 32'(o_srcb), 1);
      end
    end
  endtask

  function automatic logic [6:0] pick_opcode(input int k);
    case (k)
      0: return OPC_LUI;      1: return OPC_AUIPC;   2: return OPC_JAL;
      3: return OPC_JALR;     4: return OPC_BRANCH;  5: return OPC_LOAD;
      6: return OPC_STORE;    7: return OPC_OPIMM;   8: return OPC_OPIMM32;
      9: return OPC_OP;       10: return OPC_OP32;   default: return OPC_MISCMEM;
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    logic [6:0]  opc;
    int          idel, ddel, seen_req;
    bit          found;

    do_reset();

    // Program of three ALU instructions with immediate ready
    check_instr("addi_x3", 32'h02A00193, 0, 0, 1'b0);
    check_instr("addi_x5", 32'h00D00293, 0, 0, 1'b0);
    check_instr("add_x2",  32'h00328133, 0, 0, 1'b0);

    // Taken branch retires in EXEC; the following cycle is a fetch
    check_instr("beq_taken", 32'h00000463, 0, 0, 1'b1);
    @(negedge clk); #1;
    chk("beq_next_is_fetch", 32'(imem_req), 32'd1);
    do_reset();

    // Load with three cycles of data-memory delay
    check_instr("lw_delay3", 32'h00002083, 0, 3, 1'b0);

    // Illegal opcodes halt; no fetch afterwards
    check_instr("illegal_zero", 32'h00000000, 0, 0, 1'b0);
    seen_req = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (imem_req) seen_req++;
    end
    chk("trap_no_fetch", seen_req, 0);
    chk("trap_sticky", 32'(trap), 32'd1);
    do_reset();
    check_instr("illegal_system", 32'h00000073, 1, 0, 1'b0);
    do_reset();

    // Fetch timeout, then ready on the last allowed request cycle
    check_instr("imem_timeout", 32'h02A00193, 99, 0, 1'b0);
    do_reset();
    check_instr("imem_ready_at_limit", 32'h02A00193, TB_WAIT - 1, 0, 1'b0);
    check_instr("dmem_timeout", 32'h00002083, 0, 99, 1'b0);
    do_reset();

    // Asynchronous reset while a data request is outstanding
    instr = 32'h00002083; imem_ready = 1'b1; dmem_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #1;
      if (dmem_req) found = 1;
    end
    chk("midmem_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midmem_async_outputs_zero", 32'(all_outs), 32'd0);
    imem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("midmem_release_in_reset", 32'(imem_req), 32'd0);
    @(negedge clk); #1;
    chk("midmem_then_fetch", 32'(imem_req), 32'd1);
    chk("midmem_no_retire", 32'(retire), 32'd0);
    do_reset();

    // Random instruction stream with random handshake latencies
    for (int k = 0; k < 60; k++) begin
      w = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        do opc = 7'($urandom_range(0, 127)); while (is_legal(opc));
      end else begin
        opc = pick_opcode($urandom_range(0, 11));
      end
      w[6:0] = opc;
      if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
      idel = $urandom_range(0, 9) == 0 ? TB_WAIT : $urandom_range(0, TB_WAIT - 1);
      ddel = $urandom_range(0, 9) == 0 ? TB_WAIT : $urandom_range(0, TB_WAIT - 1);
      check_instr($sformatf("rand%0d", k), w, idel, ddel, 1'($urandom_range(0, 1)));
      if (o_trap || o_cycles >= 40) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
